// File: rtl/lab6_seq_pkg.sv
// Shared types and constants for the lab6 serial transmitter and its "1101" matcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lab6_seq_pkg;

    // Transmitter FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit pattern recognised by the lab6 sequence detectors, oldest bit first.
    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/lab6_seq_match.sv
// Overlapping "1101" matcher over a qualified bit stream; doubles as a golden detector model.
// Latency: match is registered, high in the cycle after the valid bit that completes the pattern.
// Backpressure: none; cycles with bit_vld=0 neither advance the history nor match.
module lab6_seq_match
    import lab6_seq_pkg::*;
(
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_vld,
    output logic match
);

    // Last three accepted bits, newest in bit 0.
    logic [2:0] hist;

    // Shift valid bits into the history and flag a completed pattern one cycle later.
    always_ff @(posedge clock) begin
        if (rst || clr) begin
            hist  <= 3'b000;
            match <= 1'b0;
        end else if (bit_vld) begin
            match <= ({hist, bit_in} == PATTERN);
            hist  <= {hist[1:0], bit_in};
        end else begin
            match <= 1'b0;
        end
    end

endmodule

// File: rtl/lab6_seq_tx.sv
// Serial word transmitter: sends word[len-1:0] MSB-first reps+1 times, with expected "1101" response.
// Latency: first bit one cycle after the accepting edge; done one cycle after the last bit.
// Backpressure: none; start is dropped while busy or when len is out of range.
module lab6_seq_tx
    import lab6_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] word,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       reps,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done,
    output logic             exp_found
);

    // WIDTH expressed at len's width plus one, so len values above WIDTH compare correctly.
    localparam logic [LEN_W:0] WIDTH_L = (LEN_W + 1)'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] word_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] bit_cnt;
    logic [3:0]       rep_cnt;
    logic             done_r;
    logic             done_nxt;
    logic             accept;
    logic             len_ok;
    logic [WIDTH-1:0] word_shift;

    assign len_ok = (len != '0) && ({1'b0, len} <= WIDTH_L);

    // Current bit selected by shifting rather than indexing, so bit_cnt's width need not match log2(WIDTH).
    assign word_shift = word_r >> bit_cnt;

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept legal starts in IDLE, leave SHIFT after the last bit of the last repetition.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        d_valid   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start && len_ok) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                d_valid = 1'b1;
                busy    = 1'b1;
                if ((bit_cnt == '0) && (rep_cnt == 4'd0)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request on acceptance, then walk the bit and repetition counters down.
    always_ff @(posedge clock) begin
        if (rst) begin
            word_r  <= '0;
            len_r   <= '0;
            bit_cnt <= '0;
            rep_cnt <= 4'd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= done_nxt;
            if (accept) begin
                word_r  <= word;
                len_r   <= len;
                bit_cnt <= len - ONE_L;
                rep_cnt <= reps;
            end else if (state == SHIFT) begin
                if (bit_cnt == '0) begin
                    if (rep_cnt != 4'd0) begin
                        rep_cnt <= rep_cnt - 4'd1;
                        bit_cnt <= len_r - ONE_L;
                    end
                end else begin
                    bit_cnt <= bit_cnt - ONE_L;
                end
            end
        end
    end

    assign d_out = d_valid & word_shift[0];
    assign done  = done_r;

    // History cleared on every accepted start so matches never join two transmissions.
    lab6_seq_match u_match (
        .clock   (clock),
        .rst     (rst),
        .clr     (accept),
        .bit_in  (d_out),
        .bit_vld (d_valid),
        .match   (exp_found)
    );

endmodule

// File: tb/tb_lab6_seq_tx.sv
// Directed, table-driven bench for lab6_seq_tx with hand-computed bit streams and match masks.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_lab6_seq_tx;

    logic        clock;
    logic        rst;
    logic        start;
    logic [15:0] word;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        d_out;
    logic        d_valid;
    logic        busy;
    logic        done;
    logic        exp_found;

    int errors = 0;
    int checks = 0;

    // n: valid bits; seq[i]: i-th transmitted bit; mask[i]: exp_found in the cycle after bit i.
    // poke_c: cycle (relative to acceptance) in which a stray start is driven, 0 for none.
    typedef struct {
        logic [15:0] word;
        logic [4:0]  len;
        logic [3:0]  reps;
        int          n;
        logic [63:0] seq;
        logic [63:0] mask;
        int          poke_c;
    } vec_t;

    vec_t vecs[7];
    vec_t vec_a;

    lab6_seq_tx #(.WIDTH(16), .LEN_W(5)) dut (
        .clock     (clock),
        .rst       (rst),
        .start     (start),
        .word      (word),
        .len       (len),
        .reps      (reps),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .busy      (busy),
        .done      (done),
        .exp_found (exp_found)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " d_out"}, d_out, 1'b0);
        chk({tag, " d_valid"}, d_valid, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " exp_found"}, exp_found, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a start for one edge, then scramble the request inputs to prove they were latched.
    task automatic launch(input vec_t v);
        start = 1'b1;
        word  = v.word;
        len   = v.len;
        reps  = v.reps;
        tick();
        start = 1'b0;
        word  = ~v.word;
        len   = v.len ^ 5'd3;
        reps  = ~v.reps;
    endtask

    // Check cycles 1..n+2 after acceptance; with chain set, launch nv in the done cycle instead.
    task automatic check_tx(input string tag, input vec_t v, input bit chain, input vec_t nv);
        for (int c = 1; c <= v.n + 2; c++) begin
            logic ev, ed, eo, ef;
            string nm;
            ev = (c <= v.n);
            ed = (c == v.n + 1);
            eo = ev ? v.seq[c-1] : 1'b0;
            ef = (c >= 2 && c <= v.n + 1) ? v.mask[c-2] : 1'b0;
            nm = $sformatf("%s c%0d", tag, c);
            chk({nm, " d_valid"}, d_valid, ev);
            chk({nm, " busy"}, busy, ev);
            chk({nm, " d_out"}, d_out, eo);
            chk({nm, " done"}, done, ed);
            chk({nm, " exp_found"}, exp_found, ef);
            if (chain && ed) begin
                launch(nv);
                return;
            end
            if (c == v.poke_c) begin
                start = 1'b1;
                word  = 16'h000D;
                len   = 5'd4;
                reps  = 4'd0;
            end
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{16'h000D, 5'd4,  4'd0,  4,  64'hB,        64'h8,   0};
        vecs[1] = '{16'h006D, 5'd7,  4'd0,  7,  64'h5B,       64'h48,  0};
        vecs[2] = '{16'h000D, 5'd4,  4'd2,  12, 64'hBBB,      64'h888, 0};
        vecs[3] = '{16'h0001, 5'd1,  4'd3,  4,  64'hF,        64'h0,   0};
        vecs[4] = '{16'h8001, 5'd16, 4'd0,  16, 64'h8001,     64'h0,   5};
        vecs[5] = '{16'h0006, 5'd3,  4'd2,  9,  64'hDB,       64'h48,  0};
        vecs[6] = '{16'h0002, 5'd2,  4'd15, 32, 64'h55555555, 64'h0,   0};
        vec_a   = '{16'h0006, 5'd3,  4'd0,  3,  64'h3,        64'h0,   0};

        // Reset held two cycles, start asserted alongside it.
        rst   = 1'b1;
        start = 1'b0;
        word  = 16'h0000;
        len   = 5'd0;
        reps  = 4'd0;
        tick();
        chk_idle("reset1");
        start = 1'b1;
        word  = 16'h000D;
        len   = 5'd4;
        tick();
        chk_idle("reset2");
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk_idle("post_reset1");
        tick();
        chk_idle("post_reset2");

        // Table of single transmissions.
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i]);
            check_tx($sformatf("vec%0d", i), vecs[i], 1'b0, vecs[0]);
        end

        // Out-of-range lengths are ignored.
        start = 1'b1;
        word  = 16'h000D;
        len   = 5'd0;
        tick();
        start = 1'b0;
        chk_idle("len0 c1");
        tick();
        chk_idle("len0 c2");
        start = 1'b1;
        len   = 5'd17;
        tick();
        start = 1'b0;
        chk_idle("len17 c1");
        tick();
        chk_idle("len17 c2");

        // Start in the done cycle; the second word begins with 1 after a trailing 1,1,0.
        launch(vec_a);
        check_tx("chainA", vec_a, 1'b1, vecs[2]);
        check_tx("chainB", vecs[2], 1'b0, vecs[0]);

        // Abort at bit 3 of an 8-bit word.
        launch('{16'h00FF, 5'd8, 4'd0, 8, 64'hFF, 64'h0, 0});
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("abort c%0d d_valid", c), d_valid, 1'b1);
            chk($sformatf("abort c%0d d_out", c), d_out, 1'b1);
            if (c < 3) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("abort next");
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("abort tail%0d done", c), done, 1'b0);
            chk($sformatf("abort tail%0d d_valid", c), d_valid, 1'b0);
        end
        launch(vecs[0]);
        check_tx("after_abort", vecs[0], 1'b0, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab6_seq_tx.md
LAB6_SEQ_TX -- requirements
Module: lab6_seq_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 16: maximum word length in bits.
REQ-002 SHALL have parameter LEN_W, default 5: width of len, so that len can hold WIDTH.
REQ-003 Port clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: single-cycle request; word, len and reps are sampled with it.
REQ-006 Port word, input, WIDTH: bits to send; bit len-1 goes first.
REQ-007 Port len, input, LEN_W: bits per word; legal range 1..WIDTH.
REQ-008 Port reps, input, 4: extra repetitions; the word is sent reps+1 times back-to-back.
REQ-009 Port d_out, output, 1: serial bit stream, compatible with the sequence detectors' d_in.
REQ-010 Port d_valid, output, 1: d_out carries a transmitted bit this cycle.
REQ-011 Port busy, output, 1: a transmission is in progress.
REQ-012 Port done, output, 1: one-cycle pulse when a transmission completes.
REQ-013 Port exp_found, output, 1: expected "1101" detector response, for self-checking benches.

Function
REQ-014 The FSM SHALL have two states, IDLE and SHIFT.
REQ-015 IDLE->SHIFT SHALL occur at an edge where start=1 and 1<=len<=WIDTH.
REQ-016 start SHALL be ignored when in SHIFT, or when len=0 or len>WIDTH; an ignored start produces no done pulse.
REQ-017 Bit timing: with start accepted at edge k, the first bit (word[len-1]) SHALL be on d_out with d_valid=1 in cycle k+1.
REQ-018 Bits SHALL follow one per cycle, MSB-first, down to word[0], with no gaps between repetitions.
REQ-019 Total valid cycles SHALL be len*(reps+1).
REQ-020 Completion: in the cycle after the last valid bit, d_valid=0, busy=0, done=1 for exactly one cycle, and the FSM is in IDLE.
REQ-021 A start asserted during the done cycle SHALL be accepted, giving a 1-cycle gap between transmissions.
REQ-022 word, len and reps SHALL be latched at acceptance; input changes during SHIFT have no effect.
REQ-023 busy SHALL be 1 exactly during the valid cycles.
REQ-024 Whenever d_valid=0, d_out SHALL be 0.
REQ-025 A bit counter SHALL count down from len-1 to 0, then reload to len-1 while a repetition remains.
REQ-026 A repetition counter SHALL count down from reps to 0; when reps=15, the word SHALL be sent 16 times.
REQ-027 exp_found SHALL be a registered overlapping "1101" matcher on the valid bits: it is 1 in the cycle after a valid bit that completes 1,1,0,1, and 0 otherwise.
REQ-028 Matches SHALL span repetition boundaries.
REQ-029 Matcher history SHALL be cleared on start acceptance, so no match spans two separate transmissions.
REQ-030 The matcher SHALL use only cycles with d_valid=1; idle cycles do not advance it.

Reset
REQ-031 While rst=1, the block SHALL enter IDLE, with d_out, d_valid, busy, done and exp_found all 0, and the counters and matcher history cleared.
REQ-032 rst SHALL take priority over start.
REQ-033 rst asserted mid-transmission SHALL abort with no done pulse, with outputs 0 from the next cycle.

Structure
REQ-034 Shared package lab6_seq_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the constant PATTERN = 4'b1101.
REQ-035 The matcher SHALL be a sub-module lab6_seq_match, with ports clock, rst, clr, bit_in, bit_vld and match.
REQ-036 lab6_seq_match SHALL be reusable as a golden model for the lab6 detectors.

Verification
REQ-037 Reset: rst=1 for 2 cycles, then start=1 in the same cycle as rst -> all outputs 0 and no transmission.
REQ-038 Single word: start, word=16'h000D, len=4, reps=0 at edge k -> d_out 1,1,0,1 in cycles k+1..k+4; done=1 and exp_found=1 in cycle k+5.
REQ-039 Overlap: word=7'b1101101, len=7 -> exp_found=1 in the cycles after bit 4 and after bit 7 only, then done.
REQ-040 Repeat: word=4'b1101, len=4, reps=2 -> 12 contiguous valid bits, exp_found pulses after bits 4, 8 and 12, one done.
REQ-041 Ignore: start during SHIFT and start with len=0 -> no effect, no extra done; start in the done cycle -> next first bit follows after a 1-cycle gap.
REQ-042 Abort: rst=1 at bit 3 of len=8 -> d_valid=0 and busy=0 in the next cycle, done never pulses, and a following start transmits normally.
